// File: rtl/peripheral_ahb3_spram_ws.sv
// ---------------------------------------------------------------------------
// peripheral_ahb3_spram_ws
//
// AHB3-Lite single-port SRAM slave with a generic data width, programmable
// data-phase wait states, HSIZE/HADDR-derived byte-lane writes, read-after-write
// forwarding and two-cycle ERROR responses.
//
// Ports:
//   HCLK, HRESETn        bus clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS  address-phase select, byte address, transfer type
//   HWRITE, HSIZE        direction and transfer size (0=byte .. 3=dword)
//   HBURST, HPROT,
//   HMASTLOCK            accepted but ignored
//   HWDATA               write data, valid in the data phase
//   HREADY               bus ready, qualifies address-phase sampling
//   HRDATA               registered read data
//   HREADYOUT, HRESP     slave ready and response (0=OKAY, 1=ERROR)
//
// Writes are parked for one cycle in a pending-write register and committed
// on the following edge; reads overlay both the pending write and a write
// completing on the same edge, so back-to-back write/read never stalls.
// ---------------------------------------------------------------------------
module peripheral_ahb3_spram_ws #(
  parameter int unsigned MEM_SIZE    = 1024,
  parameter int unsigned PLEN        = 16,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            HSEL,
  input  logic [PLEN-1:0] HADDR,
  input  logic [XLEN-1:0] HWDATA,
  output logic [XLEN-1:0] HRDATA,
  input  logic            HWRITE,
  input  logic [2:0]      HSIZE,
  input  logic [2:0]      HBURST,
  input  logic [3:0]      HPROT,
  input  logic [1:0]      HTRANS,
  input  logic            HMASTLOCK,
  input  logic            HREADY,
  output logic            HREADYOUT,
  output logic            HRESP
);

  localparam int unsigned Bytes     = XLEN / 8;
  localparam int unsigned AlignBits = $clog2(Bytes);
  localparam int unsigned MemBits   = $clog2(MEM_SIZE);
  localparam int unsigned Words     = MEM_SIZE / Bytes;
  localparam int unsigned WordBits  = MemBits - AlignBits;

  localparam logic [PLEN:0] MemLimit = (PLEN+1)'(MEM_SIZE);
  localparam logic [3:0]    WsLast   = 4'(WAIT_STATES);
  localparam logic [2:0]    MaxSize  = 3'(AlignBits);

  typedef enum logic [1:0] {StIdle, StData, StErr1, StErr2} state_e;

  // Lanes touched by a transfer of 2**size bytes at byte offset off.
  function automatic logic [Bytes-1:0] lane_mask(input logic [2:0]           size,
                                                 input logic [AlignBits-1:0] off);
    logic [7:0] base;
    case (size)
      3'd0:    base = 8'h01;
      3'd1:    base = 8'h03;
      3'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base[Bytes-1:0] << off;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e               st_q, st_d;
  logic [3:0]           cnt_q, cnt_d;

  // Address-phase capture
  logic                 write_q;
  logic [WordBits-1:0]  word_q;
  logic [Bytes-1:0]     mask_q;

  // Pending write
  logic                 pend_v_q;
  logic [WordBits-1:0]  pend_word_q;
  logic [Bytes-1:0]     pend_mask_q;
  logic [XLEN-1:0]      pend_data_q;

  logic [XLEN-1:0]      rdata_q;
  logic [XLEN-1:0]      mem [Words];

  // -------------------------------------------------------------------------
  // Address-phase decode
  // -------------------------------------------------------------------------
  logic accept, data_last, can_take, take;
  logic addr_err, size_err, align_err, xfer_err;

  assign accept    = HSEL & HREADY & HTRANS[1];
  assign data_last = (st_q == StData) && (cnt_q == WsLast);
  assign can_take  = (st_q == StIdle) || (st_q == StErr2) || data_last;
  assign take      = accept & can_take;

  assign addr_err  = {1'b0, HADDR} >= MemLimit;
  assign size_err  = HSIZE > MaxSize;

  always_comb begin
    align_err = 1'b0;
    case (HSIZE)
      3'd0:    align_err = 1'b0;
      3'd1:    align_err = HADDR[0];
      3'd2:    align_err = |HADDR[1:0];
      3'd3:    align_err = |HADDR[2:0];
      default: align_err = 1'b0; // oversize is flagged by size_err
    endcase
  end

  assign xfer_err = addr_err | size_err | align_err;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      st_q  <= StIdle;
      cnt_q <= 4'd0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    unique case (st_q)
      StIdle, StErr2: begin
        if (take) begin
          st_d  = xfer_err ? StErr1 : StData;
          cnt_d = 4'd0;
        end else begin
          st_d  = StIdle;
        end
      end
      StData: begin
        if (!data_last) begin
          cnt_d = cnt_q + 4'd1;
        end else if (take) begin
          st_d  = xfer_err ? StErr1 : StData;
          cnt_d = 4'd0;
        end else begin
          st_d  = StIdle;
        end
      end
      StErr1: st_d = StErr2;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    unique case (st_q)
      StIdle: ;
      StData: HREADYOUT = (cnt_q == WsLast);
      StErr1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      StErr2: HRESP = 1'b1;
    endcase
  end

  // -------------------------------------------------------------------------
  // Address-phase capture
  // -------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      write_q <= 1'b0;
      word_q  <= '0;
      mask_q  <= '0;
    end else if (take) begin
      write_q <= HWRITE;
      word_q  <= HADDR[MemBits-1:AlignBits];
      mask_q  <= lane_mask(HSIZE, HADDR[AlignBits-1:0]);
    end
  end

  // -------------------------------------------------------------------------
  // Write path: sample HWDATA on the last data-phase edge, commit one edge later
  // -------------------------------------------------------------------------
  logic wr_done;
  assign wr_done = data_last & write_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_v_q    <= 1'b0;
      pend_word_q <= '0;
      pend_mask_q <= '0;
      pend_data_q <= '0;
    end else begin
      pend_v_q <= wr_done;
      if (wr_done) begin
        pend_word_q <= word_q;
        pend_mask_q <= mask_q;
        pend_data_q <= HWDATA;
      end
    end
  end

  // Array is not reset; contents survive HRESETn.
  always_ff @(posedge HCLK) begin
    if (pend_v_q) begin
      for (int b = 0; b < Bytes; b++) begin
        if (pend_mask_q[b]) begin
          mem[pend_word_q][b*8 +: 8] <= pend_data_q[b*8 +: 8];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read path
  // -------------------------------------------------------------------------
  // HRDATA is loaded on the edge that starts the final data-phase cycle. With
  // no wait states that is the accept edge itself, so the live HADDR is used;
  // otherwise it is the edge before the counter reaches WAIT_STATES.
  logic                rd_ws0, rd_wsn, rd_load;
  logic [WordBits-1:0] rd_word;
  logic [XLEN-1:0]     rd_val;

  assign rd_ws0  = (WAIT_STATES == 0) && take && !xfer_err && !HWRITE;
  assign rd_wsn  = (WAIT_STATES != 0) && (st_q == StData) && !write_q &&
                   ((cnt_q + 4'd1) == WsLast);
  assign rd_load = rd_ws0 | rd_wsn;
  assign rd_word = (WAIT_STATES == 0) ? HADDR[MemBits-1:AlignBits] : word_q;

  // Overlay order: array, then the older pending write, then the write whose
  // data phase ends on this very edge.
  always_comb begin
    rd_val = mem[rd_word];
    for (int b = 0; b < Bytes; b++) begin
      if (pend_v_q && (pend_word_q == rd_word) && pend_mask_q[b]) begin
        rd_val[b*8 +: 8] = pend_data_q[b*8 +: 8];
      end
      if (wr_done && (word_q == rd_word) && mask_q[b]) begin
        rd_val[b*8 +: 8] = HWDATA[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rdata_q <= '0;
    end else if (rd_load) begin
      rdata_q <= rd_val;
    end
  end

  assign HRDATA = rdata_q;

  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

endmodule

// File: doc/peripheral_ahb3_spram_ws.md
Name: peripheral_ahb3_spram_ws

Overview:
- Parametrised AHB3-Lite single-port SRAM slave. Successor to the fixed-timing AHB3 SPRAM.
- Adds generic data width, programmable data-phase wait states, byte-lane writes derived from HSIZE/HADDR, and read-after-write forwarding.
- Adds two-cycle ERROR responses for out-of-range, oversize and misaligned transfers.
- Sits on the peripheral AHB3 interconnect as a scratch or data memory.

Parameters:
- MEM_SIZE, 1024, memory size in bytes; power of two, multiple of XLEN/8.
- PLEN, 16, HADDR width; must satisfy 2**PLEN >= MEM_SIZE.
- XLEN, 32, data bus width; one of 32 or 64.
- WAIT_STATES, 0, number of HREADYOUT-low cycles inserted in every OKAY data phase; range 0..15.

Ports:
- HCLK  in  1  bus clock; all state changes on its rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  PLEN  byte address.
- HWDATA  in  XLEN  write data; valid in the data phase.
- HRDATA  out  XLEN  read data; registered.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size; 0 = byte, 1 = half, 2 = word, 3 = dword.
- HBURST  in  3  ignored; every beat is treated as an independent transfer.
- HPROT  in  4  ignored.
- HTRANS  in  2  0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ.
- HMASTLOCK  in  1  ignored.
- HREADY  in  1  bus ready; qualifies address-phase sampling.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (HRESETn low, asynchronous): HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, pending-write register invalid, wait counter=0. Memory array is not cleared.
- Reset asserted mid-operation aborts any pending write; that write is lost.
- Accept condition: HSEL & HREADY & HTRANS[1]. On accept, capture HADDR, HWRITE and HSIZE.
- IDLE or BUSY with HSEL=1: next data phase is zero-wait OKAY with no memory access.
- Error checks, evaluated on accept:
  - HADDR >= MEM_SIZE → ERROR.
  - HSIZE > log2(XLEN/8) → ERROR.
  - HADDR not aligned to 2**HSIZE → ERROR.
- Byte-lane mask: (2**(2**HSIZE))-1, shifted left by HADDR[log2(XLEN/8)-1:0].
- FSM states:
  - IDLE → DATA on an accepted OKAY transfer.
  - IDLE → ERR1 on an accepted erroring transfer.
  - DATA: HREADYOUT=0 while the wait counter < WAIT_STATES, counter increments each cycle. When the counter reaches WAIT_STATES, HREADYOUT=1 and HRESP=0.
  - Leaving DATA: if a new transfer is accepted in the same cycle → DATA (counter reset) or ERR1; otherwise → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 for one cycle → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Any transfer accepted in ERR2 is processed normally.
- Erroring transfers never modify memory; HRDATA holds its previous value.
- Read:
  - The array is read synchronously using the captured word address.
  - HRDATA is valid in the final (HREADYOUT=1) data-phase cycle.
  - Latency is WAIT_STATES+1 cycles from accept.
  - Sub-word reads return the whole word; the master selects the lanes.
- Write:
  - HWDATA is sampled on the final data-phase edge into the pending-write register (word address, lane mask, data).
  - The pending write is committed to the array on the next edge, or earlier if the port is idle.
  - Only masked lanes are updated.
- Read-after-write hazard: a read whose word address matches a valid pending write returns the array word with masked lanes replaced by the pending data, with no added wait. Back-to-back writes commit in order.
- Address wrap: there is no wrap. Accesses beyond MEM_SIZE raise ERROR; the internal index uses only log2(MEM_SIZE) bits.
- Simultaneous pending commit and new read to a different word: both proceed, with the single port time-shared via the pending register. The implementation must not stall for this case.

Test Plan:
- Reset with HRESETn=0 for 3 cycles, then release → HREADYOUT=1, HRESP=0, HRDATA=0 throughout and after release.
- XLEN=32, WAIT_STATES=0: write word 0xDEADBEEF @0x10, then read @0x10 immediately → HRDATA=0xDEADBEEF in the next cycle (forwarded), with no HREADYOUT low.
- Byte writes 0x11 @0x20, 0x22 @0x21, half 0x4433 @0x22, then word read @0x20 → 0x44332211.
- WAIT_STATES=3: read → HREADYOUT low for exactly 3 cycles, data valid in the 4th.
- Read @MEM_SIZE → ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1). A word write @0x02 likewise errors, and a later read confirms memory is unchanged.
- Issue a write @0x30 of 0xA5A5A5A5 and assert HRESETn low in the cycle after its data phase, then read @0x30 → the old value is returned, and HREADYOUT is 1 during reset.
